// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths and writeback-select encodings for the integer pipeline.
//   XLEN       - integer datapath width
//   REG_ADDR_W - register address width (fixed at 5 for 32 architectural registers)
//   wb_sel_e   - writeback source select used by the MEM/WB stage
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read/1-write integer register file with hardwired x0 and write-first bypass.
//   clk, rst         - rising-edge clock, asynchronous active-high reset (clears every register)
//   we, waddr, wdata - write port; writes to address 0 are dropped
//   raddr1, rdata1   - combinational read port 1
//   raddr2, rdata2   - combinational read port 2
module regfile_2r1w
    import riscv_pkg::*;
#(
    parameter int W    = XLEN,
    parameter int NREG = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [W-1:0]          wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [W-1:0]          rdata1,
    output logic [W-1:0]          rdata2
);

    logic [W-1:0] regs [32];
    logic         wen;

    // x0 is never stored; addresses beyond NREG are treated as absent
    assign wen = we && waddr != '0 && int'(waddr) < NREG;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wen) begin
            regs[waddr] <= wdata;
        end
    end

    // Write-first: a same-cycle write to the read address is seen before the edge
    always_comb begin
        rdata1 = raddr1 == '0 || int'(raddr1) >= NREG ? '0 :
                 wen && raddr1 == waddr ? wdata : regs[raddr1];
        rdata2 = raddr2 == '0 || int'(raddr2) >= NREG ? '0 :
                 wen && raddr2 == waddr ? wdata : regs[raddr2];
    end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage - selects the writeback value, writes the register file,
// serves the decode read ports and counts retired instructions.
//   clk, rst                          - rising-edge clock, asynchronous active-high reset
//   wb_valid, wb_we, wb_rd, wb_sel    - MEM/WB control (bubble flag, write enable, dest, source)
//   wb_ALU_out, wb_DataB, wb_pc, wb_imm - writeback sources
//   rs1_addr/rs1_data, rs2_addr/rs2_data - combinational decode read ports with bypass
//   wb_data   - selected writeback value for the forwarding unit
//   wb_commit - pulse one cycle after a register write took place
//   instret   - 64-bit retired-instruction counter
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_valid,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [1:0]            wb_sel,
    input  logic [XLEN-1:0]       wb_ALU_out,
    input  logic [XLEN-1:0]       wb_DataB,
    input  logic [XLEN-1:0]       wb_pc,
    input  logic [XLEN-1:0]       wb_imm,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic [XLEN-1:0]       wb_data,
    output logic                  wb_commit,
    output logic [63:0]           instret
);

    logic wr_en;

    always_comb begin
        wb_data = wb_sel == WB_ALU ? wb_ALU_out :
                  wb_sel == WB_MEM ? wb_DataB   :
                  wb_sel == WB_PC4 ? wb_pc + XLEN'(4) : wb_imm;
    end

    assign wr_en = wb_valid && wb_we && wb_rd != '0;

    regfile_2r1w #(.W(XLEN), .NREG(NREG)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_valid && wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_commit <= 1'b0;
            instret   <= '0;
        end else begin
            wb_commit <= wr_en;
            instret   <= instret + 64'(wb_valid);
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd, rs1_addr, rs2_addr;
    logic [1:0]  wb_sel;
    logic [31:0] wb_ALU_out, wb_DataB, wb_pc, wb_imm;
    logic [31:0] rs1_data, rs2_data, wb_data;
    logic        wb_commit;
    logic [63:0] instret;

    int passed = 0;
    int total  = 0;

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_sel     (wb_sel),
        .wb_ALU_out (wb_ALU_out),
        .wb_DataB   (wb_DataB),
        .wb_pc      (wb_pc),
        .wb_imm     (wb_imm),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .wb_data    (wb_data),
        .wb_commit  (wb_commit),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Unselected sources carry distinct junk so a wrong mux leg is visible
    task automatic drive(input logic v, input logic w, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [31:0] val);
        wb_valid = v; wb_we = w; wb_rd = rd; wb_sel = sel;
        wb_ALU_out = 32'hA1A1_A1A1; wb_DataB = 32'hB2B2_B2B2;
        wb_pc = 32'hC3C3_C3C0; wb_imm = 32'hD4D4_D4D4;
        case (sel)
            2'd0: wb_ALU_out = val;
            2'd1: wb_DataB   = val;
            2'd2: wb_pc      = val;
            default: wb_imm  = val;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rs1_addr = 5'd0; rs2_addr = 5'd0;
        drive(0, 0, 5'd0, 2'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_instret", instret, 64'd0);
        chk("reset_commit", {63'd0, wb_commit}, 64'd0);
        rst = 1'b0;

        // ALU source, bypass then array read
        drive(1, 1, 5'd3, 2'd0, 32'h1234_5678); rs1_addr = 5'd3;
        #1;
        chk("alu_wb_data", {32'd0, wb_data}, {32'd0, 32'h1234_5678});
        chk("alu_bypass", {32'd0, rs1_data}, {32'd0, 32'h1234_5678});
        tick();
        drive(0, 0, 5'd0, 2'd0, 32'h0);
        #1;
        chk("alu_read", {32'd0, rs1_data}, {32'd0, 32'h1234_5678});
        chk("alu_commit", {63'd0, wb_commit}, 64'd1);
        chk("alu_instret", instret, 64'd1);

        // IMM source into x9, then PC+4 wrapping to zero overwrites it
        drive(1, 1, 5'd9, 2'd3, 32'hCAFE_F00D); rs2_addr = 5'd9;
        tick();
        drive(0, 0, 5'd0, 2'd0, 32'h0);
        #1;
        chk("imm_read", {32'd0, rs2_data}, {32'd0, 32'hCAFE_F00D});
        drive(1, 1, 5'd9, 2'd2, 32'hFFFF_FFFC);
        #1;
        chk("pc4_wrap_wb_data", {32'd0, wb_data}, 64'd0);
        tick();
        drive(1, 1, 5'd10, 2'd2, 32'h0000_0100); rs1_addr = 5'd10;
        #1;
        chk("pc4_wrap_read", {32'd0, rs2_data}, 64'd0);
        chk("pc4_bypass", {32'd0, rs1_data}, {32'd0, 32'h0000_0104});
        tick();
        chk("pc4_instret", instret, 64'd4);

        // MEM source with both ports bypassing the same register
        drive(1, 1, 5'd7, 2'd1, 32'hDEAD_BEEF); rs1_addr = 5'd7; rs2_addr = 5'd7;
        #1;
        chk("byp_rs1", {32'd0, rs1_data}, {32'd0, 32'hDEAD_BEEF});
        chk("byp_rs2", {32'd0, rs2_data}, {32'd0, 32'hDEAD_BEEF});
        tick();
        // valid but no write enable: no bypass, no commit, still retires
        drive(1, 0, 5'd7, 2'd0, 32'h1111_1111);
        #1;
        chk("nowe_rs1", {32'd0, rs1_data}, {32'd0, 32'hDEAD_BEEF});
        chk("nowe_wb_data", {32'd0, wb_data}, {32'd0, 32'h1111_1111});
        tick();
        chk("nowe_commit", {63'd0, wb_commit}, 64'd0);
        chk("nowe_instret", instret, 64'd6);
        chk("nowe_array", {32'd0, rs2_data}, {32'd0, 32'hDEAD_BEEF});

        // x0 write is discarded but still retires
        drive(1, 1, 5'd0, 2'd0, 32'hFFFF_FFFF); rs1_addr = 5'd0;
        #1;
        chk("x0_same", {32'd0, rs1_data}, 64'd0);
        tick();
        drive(0, 0, 5'd0, 2'd0, 32'h0);
        #1;
        chk("x0_next", {32'd0, rs1_data}, 64'd0);
        chk("x0_commit", {63'd0, wb_commit}, 64'd0);
        chk("x0_instret", instret, 64'd7);

        // bubble with stale write enable
        drive(0, 1, 5'd4, 2'd0, 32'hAAAA_AAAA); rs1_addr = 5'd4;
        #1;
        chk("bub_same", {32'd0, rs1_data}, 64'd0);
        tick();
        chk("bub_array", {32'd0, rs1_data}, 64'd0);
        chk("bub_instret", instret, 64'd7);
        chk("bub_commit", {63'd0, wb_commit}, 64'd0);

        // asynchronous reset mid-cycle after writing x5
        drive(1, 1, 5'd5, 2'd0, 32'h0000_0055); rs1_addr = 5'd5;
        tick();
        drive(0, 0, 5'd0, 2'd0, 32'h0);
        #1;
        chk("x5_before_rst", {32'd0, rs1_data}, {32'd0, 32'h0000_0055});
        rst = 1'b1;
        #1;
        chk("rst_x5", {32'd0, rs1_data}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_commit", {63'd0, wb_commit}, 64'd0);
        // a write held across an edge under reset is cancelled
        drive(1, 1, 5'd6, 2'd0, 32'h0000_0066); rs1_addr = 5'd6;
        tick();
        rst = 1'b0;
        drive(0, 0, 5'd0, 2'd0, 32'h0);
        #1;
        chk("rst_cancel", {32'd0, rs1_data}, 64'd0);
        chk("rst_cancel_instret", instret, 64'd0);
        // first edge with reset low accepts the write
        drive(1, 1, 5'd6, 2'd0, 32'h0000_0077);
        tick();
        drive(0, 0, 5'd0, 2'd0, 32'h0);
        #1;
        chk("post_rst_write", {32'd0, rs1_data}, {32'd0, 32'h0000_0077});
        chk("post_rst_instret", instret, 64'd1);
        chk("post_rst_commit", {63'd0, wb_commit}, 64'd1);

        // instret wrap
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret;
        #1;
        chk("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1, 0, 5'd0, 2'd0, 32'h0);
        tick();
        drive(0, 0, 5'd0, 2'd0, 32'h0);
        chk("wrap_instret", instret, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side consumer of the MEM/WB pipeline register. It selects the writeback value, writes it into the 32×32 integer register file, and serves the two decode-stage read ports with same-cycle write bypass. It also keeps a retired-instruction counter. It sits between the MEM/WB register outputs and the ID stage, and feeds the forwarding unit with the final writeback data.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers (address width fixed at 5)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- wb_valid  in  1  MEM/WB slot holds a real (non-bubble) instruction
- wb_we  in  1  register write enable from MEM/WB
- wb_rd  in  5  destination register
- wb_sel  in  2  writeback source select (see Operation)
- wb_ALU_out  in  XLEN  ALU result
- wb_DataB  in  XLEN  load data from data memory
- wb_pc  in  XLEN  PC of the writeback instruction
- wb_imm  in  XLEN  immediate (LUI)
- rs1_addr  in  5  read port 1 address
- rs2_addr  in  5  read port 2 address
- rs1_data  out  XLEN  read port 1 data (combinational)
- rs2_data  out  XLEN  read port 2 data (combinational)
- wb_data  out  XLEN  selected writeback value, to forwarding unit (combinational)
- wb_commit  out  1  registered pulse: a write committed last cycle
- instret  out  64  count of retired instructions

## Operation
- Writeback mux on wb_sel:
  - 0 selects wb_ALU_out.
  - 1 selects wb_DataB.
  - 2 selects wb_pc + 4, computed mod 2^XLEN.
  - 3 selects wb_imm.
- Write condition: wb_valid && wb_we && wb_rd != 0. The register file captures wb_data at regs[wb_rd] on the rising clk.
- x0 is never stored. Reads of address 0 always return 0.
- Bypass is write-first. If the write condition holds and rsN_addr == wb_rd, rsN_data = wb_data in the same cycle. Otherwise rsN_data = regs[rsN_addr].
- instret increments by 1 on every clk where wb_valid = 1, regardless of wb_we or wb_rd. It wraps from 2^64-1 to 0.
- wb_commit is registered. It is high in the cycle after a cycle in which the write condition held.
- Reset (rst high, asynchronous): all regs[1..31] = 0, instret = 0, wb_commit = 0.
  - rst asserted during a write cancels that write.
  - The first write after reset is accepted on the first rising clk with rst low.
- wb_valid = 0 with wb_we = 1 (a bubble carrying stale control) performs no write and does not count.

## Timing
- Write latency: 1 clk. A value written at edge N is readable from the array after edge N. Same-cycle readers see it via bypass before edge N.
- rs1_data, rs2_data and wb_data are purely combinational, with no registered stage on read.
- instret and wb_commit update on the rising clk. Both are 0 while rst is high.
- Simultaneous events:
  - rs1_addr == rs2_addr == wb_rd: both ports return wb_data.
  - wb_rd = 0 with rsN_addr = 0: the port returns 0, with no bypass.

## Structure
- Shared package riscv_pkg holds:
  - the wb_sel encodings as enum wb_sel_e: WB_ALU = 0, WB_MEM = 1, WB_PC4 = 2, WB_IMM = 3
  - the XLEN and REG_ADDR_W constants
- One sub-module, regfile_2r1w, contains the array, the x0 handling, the bypass and the reset.
- The top level contains the wb_sel mux, the instret counter and wb_commit.

## Test plan
- Reset clears state: assert rst mid-run after writes to x5 → rs1_data for x5 reads 0 immediately, instret = 0, wb_commit = 0.
- Write and read each source:
  - wb_sel = 0, wb_ALU_out = 0x1234_5678, rd = 3 → next cycle rs1_addr = 3 reads 0x1234_5678.
  - wb_sel = 2, wb_pc = 0xFFFF_FFFC → stored value is 0x0000_0000.
- Bypass: rd = 7, wb_sel = 1, wb_DataB = 0xDEAD_BEEF, and in the same cycle rs1_addr = rs2_addr = 7 → both ports read 0xDEAD_BEEF before the edge.
- x0 protection: write rd = 0 with data 0xFFFF_FFFF → rs1_addr = 0 reads 0 in the same and the next cycle. wb_commit stays 0. instret still increments.
- Bubble: wb_valid = 0, wb_we = 1, rd = 4, data 0xAAAA_AAAA → x4 unchanged, instret unchanged.
- instret wrap: force instret to 2^64-1, one valid retire → instret = 0.
